// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the MEM stage.
// Valid/ready handshake on both sides: a transfer happens on a rising clk
// edge where valid and ready are both high. One request is in flight at a
// time. The response appears LATENCY edges after the accepting edge and is
// held until the requester takes it.
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_error,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int HI = 3 + AW;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic          r_write;
  logic [63:0]   r_addr;
  logic [63:0]   r_wdata;
  logic [63:0]   r_mem [DEPTH];

  logic [AW-1:0] w_idx;
  logic          w_err;
  logic          w_commit;
  logic          w_do_write;

  // Decode of the latched address: word index and misalignment/range error.
  always_comb begin
    w_idx      = r_addr[HI-1:3];
    w_err      = (|r_addr[2:0]) | (|r_addr[63:HI]);
    w_commit   = (r_state == S_WAIT) && (r_cnt == 4'd0);
    w_do_write = w_commit && r_write && !w_err;
  end

  // Storage array; never reset, written only by a valid store at commit time.
  always_ff @(posedge clk) begin
    if (w_do_write) begin
      r_mem[w_idx] <= r_wdata;
    end
  end

  // Control FSM with registered handshake and response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_write   <= 1'b0;
      r_addr    <= 64'd0;
      r_wdata   <= 64'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 64'd0;
      rsp_error <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_write   <= req_write;
            r_addr    <= req_addr;
            r_wdata   <= req_wdata;
            r_cnt     <= CNT_LOAD;
            r_state   <= S_WAIT;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        S_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            // Stores and errors return zero data; loads return the stored word.
            r_state   <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_error <= w_err;
            rsp_rdata <= (w_err || r_write) ? 64'd0 : r_mem[w_idx];
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_state   <= S_IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= 64'd0;
            rsp_error <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_cnt     <= 4'd0;
          rsp_valid <= 1'b0;
          rsp_rdata <= 64'd0;
          rsp_error <= 1'b0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
